// File: rtl/password_cracker_par.sv
// Multi-lane brute-force cracker over a 36-symbol charset (A-Z, 0-9); leftmost symbol bounded to [from,to].
// Optional attempts counter is enabled by defining PC_ATTEMPT_COUNT_EN.
module password_cracker_par #(
  parameter int unsigned N_CHARS = 4,
  parameter int unsigned LANES   = 4
`ifdef PC_ATTEMPT_COUNT_EN
  , parameter int unsigned ATT_W = 48
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*N_CHARS-1:0]   password_to_crack,
  input  logic [5:0]             from,
  input  logic [5:0]             to,
  output logic                   busy,
  output logic                   found,
  output logic                   done,
  output logic                   range_err,
  output logic [8*N_CHARS-1:0]   result
`ifdef PC_ATTEMPT_COUNT_EN
  , output logic [ATT_W-1:0]     attempts
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_FINISH} state_e;

  state_e                      state_q, state_d;
  logic [N_CHARS-1:0][5:0]     digit_q, digit_d, digit_inc;
  logic [8*N_CHARS-1:0]        target_q, target_d, result_q, result_d, hit_str;
  logic [5:0]                  to_q, to_d;
  logic                        armed_q, armed_d, err_q, err_d;
  logic                        found_q, found_d, done_q, done_d, range_err_q, range_err_d;
  logic [8*N_CHARS-1:0]        cand [LANES];
  logic [LANES-1:0]            lane_ok, lane_hit;
  logic                        range_ok, accept, hit, last_grp, carry;
  logic [6:0]                  sum0;

  function automatic logic [7:0] sym_ascii(input logic [5:0] s);
    return (s < 6'd26) ? 8'd65 + {2'b00, s} : 8'd22 + {2'b00, s};
  endfunction

  assign range_ok = (from <= to) && (to <= 6'd35);
  assign accept   = start && (state_q != S_SEARCH);

  // digit_q[N_CHARS-1] is the leftmost symbol, digit_q[0] the rightmost
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      cand[k] = '0;
      for (int unsigned i = 0; i < N_CHARS; i++) cand[k][8*i +: 8] = sym_ascii(digit_q[i]);
      cand[k][7:0] = sym_ascii(digit_q[0] + 6'(k));
      lane_ok[k]   = (N_CHARS > 1) || (({1'b0, digit_q[0]} + 7'(k)) <= {1'b0, to_q});
      lane_hit[k]  = lane_ok[k] && (cand[k] == target_q);
    end
  end

  always_comb begin
    hit     = |lane_hit;
    hit_str = '0;
    for (int unsigned k = LANES; k > 0; k--) if (lane_hit[k-1]) hit_str = cand[k-1];
  end

  always_comb begin
    if (N_CHARS == 1) begin
      last_grp = ({1'b0, digit_q[0]} + 7'(LANES - 1)) >= {1'b0, to_q};
    end else begin
      last_grp = (digit_q[N_CHARS-1] == to_q) && (digit_q[0] == 6'(36 - LANES));
      for (int unsigned i = 1; i < N_CHARS - 1; i++) last_grp = last_grp && (digit_q[i] == 6'd35);
    end
  end

  always_comb begin
    digit_inc = digit_q;
    sum0      = {1'b0, digit_q[0]} + 7'(LANES);
    carry     = (sum0 >= 7'd36);
    digit_inc[0] = carry ? 6'd0 : sum0[5:0];
    for (int unsigned i = 1; i < N_CHARS; i++) begin
      if (carry) begin
        carry        = (digit_q[i] == 6'd35);
        digit_inc[i] = carry ? 6'd0 : digit_q[i] + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // The first SEARCH cycle only arms the comparators; group 0 is tested the cycle after
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FINISH: if (start) state_d = range_ok ? S_SEARCH : S_FINISH;
      S_SEARCH: begin
        if (abort)                           state_d = S_IDLE;
        else if (armed_q && (hit || last_grp)) state_d = S_FINISH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == S_SEARCH);
    target_d    = target_q;
    to_d        = to_q;
    digit_d     = digit_q;
    armed_d     = armed_q;
    err_d       = err_q;
    found_d     = found_q;
    done_d      = done_q;
    range_err_d = range_err_q;
    result_d    = result_q;
    if (accept) begin
      target_d             = password_to_crack;
      to_d                 = to;
      digit_d              = '0;
      digit_d[N_CHARS-1]   = from;
      armed_d              = 1'b0;
      err_d                = !range_ok;
      found_d              = 1'b0;
      done_d               = 1'b0;
      range_err_d          = 1'b0;
      result_d             = '0;
    end else if (state_q == S_SEARCH && !abort) begin
      if (!armed_q) begin
        armed_d = 1'b1;
      end else if (hit) begin
        found_d  = 1'b1;
        done_d   = 1'b1;
        result_d = hit_str;
      end else begin
        digit_d = digit_inc;
        done_d  = last_grp;
      end
    end else if (state_q == S_FINISH) begin
      done_d      = 1'b1;
      range_err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q    <= '0;
      to_q        <= '0;
      digit_q     <= '0;
      armed_q     <= 1'b0;
      err_q       <= 1'b0;
      found_q     <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      result_q    <= '0;
    end else begin
      target_q    <= target_d;
      to_q        <= to_d;
      digit_q     <= digit_d;
      armed_q     <= armed_d;
      err_q       <= err_d;
      found_q     <= found_d;
      done_q      <= done_d;
      range_err_q <= range_err_d;
      result_q    <= result_d;
    end
  end

  assign found     = found_q;
  assign done      = done_q;
  assign range_err = range_err_q;
  assign result    = result_q;

`ifdef PC_ATTEMPT_COUNT_EN
  logic [ATT_W-1:0] att_q, att_d;
  logic [ATT_W:0]   att_sum;
  logic [7:0]       att_inc;

  always_comb begin
    att_inc = 8'(LANES);
    for (int unsigned k = LANES; k > 0; k--) if (lane_hit[k-1]) att_inc = 8'(k);
    att_sum = {1'b0, att_q} + {{(ATT_W-7){1'b0}}, att_inc};
    att_d   = att_q;
    if (accept)                                    att_d = '0;
    else if (state_q == S_SEARCH && !abort && armed_q) att_d = att_sum[ATT_W] ? '1 : att_sum[ATT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) att_q <= '0;
    else     att_q <= att_d;
  end

  assign attempts = att_q;
`endif

endmodule
